// File: rtl/array_prod.sv
// -----------------------------------------------------------------------------
// array_prod
//
// Sequential signed fixed-point dot product of two ARRAY_SZ-element vectors.
// Elements are QN.QM two's-complement values, W = QN+QM+1 bits wide. One
// element product is accumulated per clock. The final sum is arithmetically
// shifted right by QM, which truncates toward minus infinity.
//
// Build option:
//   ARRAY_PROD_SAT_EN  defined   -> clamp the shifted sum to the W-bit range
//                      undefined -> keep the low W bits (two's-complement wrap)
//   Latency and handshake are the same in both builds.
//
// Ports:
//   vecA      in   ARRAY_SZ*W  operand A; element i is at [i*W +: W]
//   vecB      in   ARRAY_SZ*W  operand B; same packing as vecA
//   clock     in   1           rising-edge clock
//   reset     in   1           synchronous, active-high; releasing it starts
//                              a computation
//   dataReady out  1           result valid; stays high until the next reset
//   result    out  W           dot product in QN.QM format
//   fsmState  out  2           debug view of the FSM state
//                              (0 IDLE, 1 LOAD, 2 ACC, 3 DONE)
//
// Handshake: reset high clears everything and holds the FSM in IDLE. The
// first rising edge with reset low (E0) captures vecA/vecB. Edges E1..E_N
// each accumulate one element, lowest index first. Edge E(N+1) registers
// result and raises dataReady. Both outputs then stay frozen until reset.
// Input changes after E0 are ignored.
// -----------------------------------------------------------------------------
module array_prod #(
  parameter int ARRAY_SZ = 8,
  parameter int QN       = 6,
  parameter int QM       = 11,
  localparam int W       = QN + QM + 1
) (
  input  logic [ARRAY_SZ*W-1:0] vecA,
  input  logic [ARRAY_SZ*W-1:0] vecB,
  input  logic                  clock,
  input  logic                  reset,
  output logic                  dataReady,
  output logic [W-1:0]          result,
  output logic [1:0]            fsmState
);

  // The accumulator has headroom for ARRAY_SZ full-precision products plus a
  // sign bit, so intermediate sums cannot overflow.
  localparam int AW = 2 * W + $clog2(ARRAY_SZ) + 1;
  // The counter must reach ARRAY_SZ itself, because that value marks the
  // "all elements accumulated" cycle.
  localparam int CW = $clog2(ARRAY_SZ + 1);
  localparam logic [CW-1:0] CNT_END = CW'(ARRAY_SZ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  logic [ARRAY_SZ*W-1:0] aReg;
  logic [ARRAY_SZ*W-1:0] bReg;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;

  logic signed [W-1:0]   opA;
  logic signed [W-1:0]   opB;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prodExt;
  logic signed [AW-1:0]  sumShift;
  logic [W-1:0]          resultNext;
  int                    selIdx;

  assign fsmState = state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // The operand capture happens on the edge that leaves IDLE (E0), so the
  // FSM goes directly from IDLE to ACC. LOAD names that capture step in the
  // encoding. If LOAD is ever reached, it behaves like IDLE: it recaptures
  // the operands and proceeds to ACC.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = ACC;
      LOAD: stateNext = ACC;
      ACC:  if (cnt == CNT_END) stateNext = DONE;
      DONE: stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Element select and full-precision product
  // When the counter reaches CNT_END, the index is clamped to 0. This keeps
  // the part-select in range. The product is not used in that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    selIdx = 0;
    if (cnt < CNT_END) begin
      selIdx = int'(cnt);
    end
  end

  assign opA     = aReg[selIdx*W +: W];
  assign opB     = bReg[selIdx*W +: W];
  assign prod    = opA * opB;
  assign prodExt = {{(AW - 2 * W){prod[2*W-1]}}, prod};

  // Arithmetic shift of the signed accumulator gives the floor division.
  assign sumShift = acc >>> QM;

`ifdef ARRAY_PROD_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  always_comb begin
    resultNext = sumShift[W-1:0];
    if (sumShift > SAT_MAX) begin
      resultNext = SAT_MAX[W-1:0];
    end else if (sumShift < SAT_MIN) begin
      resultNext = SAT_MIN[W-1:0];
    end
  end
`else
  // Wrap mode keeps the low W bits. The upper bits are intentionally dropped.
  logic unusedShiftBits;
  assign unusedShiftBits = ^sumShift[AW-1:W];

  always_comb begin
    resultNext = sumShift[W-1:0];
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      aReg      <= '0;
      bReg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      dataReady <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          aReg      <= vecA;
          bReg      <= vecB;
          acc       <= '0;
          cnt       <= '0;
          dataReady <= 1'b0;
        end
        ACC: begin
          if (cnt != CNT_END) begin
            acc <= acc + prodExt;
            cnt <= cnt + CW'(1);
          end else begin
            result    <= resultNext;
            dataReady <= 1'b1;
          end
        end
        default: begin
          // DONE: outputs stay frozen until the next reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_prod.sv
module tb_array_prod;

  localparam int N  = 8;
  localparam int QN = 6;
  localparam int QM = 11;
  localparam int W  = QN + QM + 1;
  localparam int VW = N * W;
  localparam int LATENCY = N + 2;

  logic [VW-1:0] vecA;
  logic [VW-1:0] vecB;
  logic          clock;
  logic          reset;
  logic          dataReady;
  logic [W-1:0]  result;
  logic [1:0]    fsmState;

  int testsRun;
  int testsFailed;

  logic [W-1:0] expQ[$];

  array_prod #(.ARRAY_SZ(N), .QN(QN), .QM(QM)) dut (
    .vecA      (vecA),
    .vecB      (vecB),
    .clock     (clock),
    .reset     (reset),
    .dataReady (dataReady),
    .result    (result),
    .fsmState  (fsmState)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint elemOf(input logic [VW-1:0] v, input int i);
    logic signed [W-1:0] e;
    e = v[i*W +: W];
    return longint'(e);
  endfunction

  function automatic logic [W-1:0] model(input logic [VW-1:0] a,
                                         input logic [VW-1:0] b);
    longint sum;
    longint sh;
    logic [63:0] shBits;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum += elemOf(a, i) * elemOf(b, i);
    end
    sh = sum >>> QM;
`ifdef ARRAY_PROD_SAT_EN
    if (sh > (longint'(1) <<< (W - 1)) - 1) sh = (longint'(1) <<< (W - 1)) - 1;
    if (sh < -(longint'(1) <<< (W - 1)))    sh = -(longint'(1) <<< (W - 1));
`endif
    shBits = sh;
    return shBits[W-1:0];
  endfunction

  function automatic logic [VW-1:0] fillVec(input logic [W-1:0] e);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = e;
    return v;
  endfunction

  function automatic logic [VW-1:0] randVec(input int lo, input int hi);
    logic [VW-1:0] v;
    int x;
    for (int i = 0; i < N; i++) begin
      x = $urandom_range(hi - lo, 0) + lo;
      v[i*W +: W] = W'(x);
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full computation, with optional input scrambling after E0
  // ---------------------------------------------------------------------------
  task automatic runCompute(input string tag, input logic [VW-1:0] a,
                            input logic [VW-1:0] b, input bit scramble);
    int edges;
    bit got;
    logic [W-1:0] exp;
    vecA = a;
    vecB = b;
    expQ.push_back(model(a, b));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 4 * LATENCY) begin
      @(posedge clock);
      edges++;
      #1;
      if (dataReady) got = 1'b1;
      if (scramble && edges == 1) begin
        vecA = randVec(0, (1 << W) - 1);
        vecB = randVec(0, (1 << W) - 1);
      end
    end
    checkValue({tag, "_latency"}, 64'(edges), 64'(LATENCY));
    exp = expQ.pop_front();
    checkValue({tag, "_result"}, 64'(result), 64'(exp));
    // Outputs must stay frozen in DONE, even when the inputs move.
    vecA = randVec(0, (1 << W) - 1);
    vecB = randVec(0, (1 << W) - 1);
    repeat (3) @(posedge clock);
    #1;
    checkValue({tag, "_ready_hold"}, 64'(dataReady), 64'(1));
    checkValue({tag, "_result_hold"}, 64'(result), 64'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    testsRun = 0;
    testsFailed = 0;
    vecA = '0;
    vecB = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkValue("reset_ready", 64'(dataReady), 64'(0));
    checkValue("reset_result", 64'(result), 64'(0));
    checkValue("reset_state", 64'(fsmState), 64'(0));

    // 1.0 . 1.0 over 8 elements -> 8.0
    runCompute("ones", fillVec(18'h00800), fillVec(18'h00800), 1'b0);
    checkValue("ones_abs", 64'(result), 64'(18'h04000));

    // 1.0 . -0.5 -> -4.0
    runCompute("neg_half", fillVec(18'h00800), fillVec(18'h3FC00), 1'b0);
    checkValue("neg_half_abs", 64'(result), 64'(18'h3E000));

    // 7.0 . 7.0 -> 392.0, out of range
    runCompute("overflow", fillVec(18'h03800), fillVec(18'h03800), 1'b0);
`ifdef ARRAY_PROD_SAT_EN
    checkValue("overflow_abs", 64'(result), 64'(18'h1FFFF));
`else
    checkValue("overflow_abs", 64'(result), 64'(18'h04000));
`endif

    // Truncation toward minus infinity
    a = '0; b = '0;
    a[W-1:0] = 18'h00001;
    b[W-1:0] = 18'h00001;
    runCompute("trunc_pos", a, b, 1'b0);
    checkValue("trunc_pos_abs", 64'(result), 64'(18'h00000));
    a[W-1:0] = 18'h3FFFF;
    runCompute("trunc_neg", a, b, 1'b0);
    checkValue("trunc_neg_abs", 64'(result), 64'(18'h3FFFF));

    // Abort at E4: reset released, then sampled high on the fifth edge
    vecA = fillVec(18'h00800);
    vecB = fillVec(18'h00800);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);   // E0..E3
    @(negedge clock);
    checkValue("abort_pre_ready", 64'(dataReady), 64'(0));
    reset = 1'b1;
    @(posedge clock);              // E4 with reset high
    #1;
    checkValue("abort_ready", 64'(dataReady), 64'(0));
    checkValue("abort_result", 64'(result), 64'(0));
    checkValue("abort_state", 64'(fsmState), 64'(0));
    runCompute("after_abort", fillVec(18'h00800), fillVec(18'h00800), 1'b0);

    // Inputs changed right after capture must be ignored
    for (int t = 0; t < 3; t++) begin
      a = randVec(0, (1 << W) - 1);
      b = randVec(0, (1 << W) - 1);
      runCompute("scramble", a, b, 1'b1);
    end

    // Small-magnitude random operands (mostly in range for both builds)
    for (int t = 0; t < 4; t++) begin
      a = randVec(-4096, 4096);
      b = randVec(-4096, 4096);
      runCompute("random", a, b, 1'b0);
    end

    checkValue("queue_empty", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
